// File: rtl/runner.sv
// runner_pkg / runner
//
// Player controller for the runner game. It holds the T-rex jump and duck
// physics and the run/duck animation frame. All state advances only on the
// one-cycle frame tick 'update'. The T-rex sprite and its screen position are
// published in render slot 0. Every other render slot is held empty.
//
// Ports
//   clk      in   system clock
//   rst      in   synchronous, active-high reset
//   update   in   one-cycle frame tick
//   jumping  in   jump key level, sampled on update
//   ducking  in   duck key level, sampled on update
//   sprite   out  sprite id per render slot (slot 0 = trex, others NONE)
//   pos      out  pos[i][0] = x, pos[i][1] = y, pixels, top-left origin
//
// The vertical position and velocity are signed 16-bit values with 4
// fractional bits (units of 1/16 px). Sprite and position outputs are
// registered, so they change one cycle after the update that causes them.
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | standing on the ground before the first jump
// RUNNING | on the ground, running animation
// JUMPING | airborne, physics integrated once per update
// DUCKING | on the ground, duck key held, shorter sprite drawn lower

package runner_pkg;
    localparam int RENDER_SLOTS = 4;

    typedef enum logic [2:0] {
        NONE,
        TREX_STANDING,
        TREX_JUMPING,
        TREX_RUNNING_1,
        TREX_RUNNING_2,
        TREX_DUCKING_1,
        TREX_DUCKING_2
    } sprite_t;
endpackage

module runner
    import runner_pkg::*;
#(
    parameter int X_POS       = 50,
    parameter int GROUND_Y    = 93,
    parameter int DUCK_DY     = 17,
    parameter int MIN_JUMP    = 30,
    parameter int MAX_JUMP_Y  = 30,
    parameter int ANIM_FRAMES = 5
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        update,
    input  logic        jumping,
    input  logic        ducking,
    output sprite_t     sprite [RENDER_SLOTS],
    output logic [10:0] pos    [RENDER_SLOTS][2]
);

    typedef enum logic [1:0] {IDLE, RUNNING, JUMPING, DUCKING} state_t;

    localparam logic signed [15:0] GROUND_FX = 16'(GROUND_Y * 16);
    localparam logic signed [15:0] MIN_LINE  = 16'(GROUND_Y - MIN_JUMP);
    localparam logic signed [15:0] MAX_LINE  = 16'(MAX_JUMP_Y);
    localparam logic signed [15:0] JUMP_VEL  = -16'sd160;
    localparam logic signed [15:0] DROP_VEL  = -16'sd80;
    localparam logic signed [15:0] DUCK_VEL  = 16'sd16;
    localparam logic signed [15:0] GRAV      = 16'sd10;
    localparam logic signed [15:0] GRAV_FAST = 16'sd30;
    localparam logic [2:0]         CNT_LAST  = 3'(ANIM_FRAMES - 1);

    state_t             state, state_nx;
    logic signed [15:0] y_fx, y_nx;
    logic signed [15:0] vel_fx, vel_nx;
    logic               rmin, rmin_nx;
    logic               sdrop, sdrop_nx;
    logic [2:0]         cnt, cnt_nx;
    logic               frame, frame_nx;
    sprite_t            spr_q, spr_nx;
    logic [10:0]        ypx_q, ypx_nx;

    logic signed [15:0] y_tmp;
    logic signed [15:0] vel_tmp;
    logic signed [15:0] ypx_tmp;
    logic               rmin_tmp;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            y_fx   <= GROUND_FX;
            vel_fx <= '0;
            rmin   <= 1'b0;
            sdrop  <= 1'b0;
            cnt    <= '0;
            frame  <= 1'b0;
            spr_q  <= TREX_STANDING;
            ypx_q  <= 11'(GROUND_Y);
        end else begin
            state  <= state_nx;
            y_fx   <= y_nx;
            vel_fx <= vel_nx;
            rmin   <= rmin_nx;
            sdrop  <= sdrop_nx;
            cnt    <= cnt_nx;
            frame  <= frame_nx;
            spr_q  <= spr_nx;
            ypx_q  <= ypx_nx;
        end
    end

    always_comb begin
        state_nx = state;
        y_nx     = y_fx;
        vel_nx   = vel_fx;
        rmin_nx  = rmin;
        sdrop_nx = sdrop;
        cnt_nx   = cnt;
        frame_nx = frame;
        y_tmp    = y_fx;
        vel_tmp  = vel_fx;
        ypx_tmp  = y_fx >>> 4;
        rmin_tmp = rmin;

        if (update) begin
            case (state)
                IDLE: begin
                    if (jumping) begin
                        state_nx = JUMPING;
                        vel_nx   = JUMP_VEL;
                    end
                end
                RUNNING, DUCKING: begin
                    if (jumping) begin
                        state_nx = JUMPING;
                        vel_nx   = JUMP_VEL;
                    end else if ((state == RUNNING) == ducking) begin
                        // Switching between running and ducking restarts the animation.
                        state_nx = ducking ? DUCKING : RUNNING;
                        cnt_nx   = '0;
                        frame_nx = 1'b0;
                    end else if (cnt == CNT_LAST) begin
                        cnt_nx   = '0;
                        frame_nx = ~frame;
                    end else begin
                        cnt_nx   = cnt + 3'd1;
                    end
                end
                JUMPING: begin
                    y_tmp    = y_fx + vel_fx;
                    vel_tmp  = vel_fx + (sdrop ? GRAV_FAST : GRAV);
                    ypx_tmp  = y_tmp >>> 4;
                    rmin_tmp = rmin | (ypx_tmp <= MIN_LINE);
                    // Too high, or the key was released after the minimum height:
                    // limit the upward speed so the jump tops out sooner.
                    if ((ypx_tmp < MAX_LINE) || (rmin_tmp && !jumping)) begin
                        if (vel_tmp < DROP_VEL) vel_tmp = DROP_VEL;
                    end
                    // Ducking in the air kicks the trex downward once per jump.
                    if (ducking && !sdrop) begin
                        sdrop_nx = 1'b1;
                        vel_tmp  = DUCK_VEL;
                    end
                    if (y_tmp >= GROUND_FX) begin
                        y_nx     = GROUND_FX;
                        vel_nx   = '0;
                        rmin_nx  = 1'b0;
                        sdrop_nx = 1'b0;
                        cnt_nx   = '0;
                        frame_nx = 1'b0;
                        state_nx = ducking ? DUCKING : RUNNING;
                    end else begin
                        y_nx     = y_tmp;
                        vel_nx   = vel_tmp;
                        rmin_nx  = rmin_tmp;
                    end
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    always_comb begin
        spr_nx = TREX_STANDING;
        case (state_nx)
            IDLE:    spr_nx = TREX_STANDING;
            JUMPING: spr_nx = TREX_JUMPING;
            RUNNING: spr_nx = frame_nx ? TREX_RUNNING_2 : TREX_RUNNING_1;
            DUCKING: spr_nx = frame_nx ? TREX_DUCKING_2 : TREX_DUCKING_1;
            default: spr_nx = TREX_STANDING;
        endcase
        // y_fx stays within 0..GROUND_FX, so bits [14:4] hold the floored pixel row.
        ypx_nx = y_nx[14:4] + ((state_nx == DUCKING) ? 11'(DUCK_DY) : 11'd0);
    end

    always_comb begin
        for (int i = 0; i < RENDER_SLOTS; i++) begin
            sprite[i] = NONE;
            pos[i][0] = '0;
            pos[i][1] = '0;
        end
        sprite[0] = spr_q;
        pos[0][0] = 11'(X_POS);
        pos[0][1] = ypx_q;
    end

endmodule

// File: tb/tb_runner.sv
module tb_runner;
    import runner_pkg::*;

    logic        clk;
    logic        rst;
    logic        update;
    logic        jumping;
    logic        ducking;
    sprite_t     sprite [RENDER_SLOTS];
    logic [10:0] pos    [RENDER_SLOTS][2];

    int vectors     = 0;
    int miscompares = 0;

    runner dut (
        .clk     (clk),
        .rst     (rst),
        .update  (update),
        .jumping (jumping),
        .ducking (ducking),
        .sprite  (sprite),
        .pos     (pos)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_trex(input string tag, input sprite_t exp_spr, input int exp_y);
        check({tag, " sprite"}, 16'(sprite[0]), 16'(exp_spr));
        check({tag, " x"}, 16'(pos[0][0]), 16'd50);
        check({tag, " y"}, 16'(pos[0][1]), 16'(exp_y));
    endtask

    task automatic step(input logic j, input logic d);
        @(negedge clk);
        update  = 1'b1;
        jumping = j;
        ducking = d;
        @(negedge clk);
        update  = 1'b0;
    endtask

    initial begin
        int n;
        int apex;
        logic landed;

        rst = 1'b1; update = 1'b0; jumping = 1'b0; ducking = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // 1: reset state and empty slots
        check_trex("reset", TREX_STANDING, 93);
        check("slot1 sprite", 16'(sprite[1]), 16'(NONE));
        check("slot1 x", 16'(pos[1][0]), 16'd0);
        check("slot1 y", 16'(pos[1][1]), 16'd0);
        check("slot3 sprite", 16'(sprite[3]), 16'(NONE));
        jumping = 1'b1;
        repeat (3) @(negedge clk);
        check_trex("idle no update", TREX_STANDING, 93);
        step(1'b0, 1'b0);
        check_trex("idle update", TREX_STANDING, 93);

        // 2: full-height jump with the key held
        step(1'b1, 1'b0);
        check_trex("jump entry", TREX_JUMPING, 93);
        step(1'b1, 1'b0);
        check_trex("jump u1", TREX_JUMPING, 83);
        step(1'b1, 1'b0);
        check_trex("jump u2", TREX_JUMPING, 73);
        n = 2; apex = 93; landed = 1'b0;
        while (!landed && n < 60) begin
            step(1'b1, 1'b0);
            n++;
            if (n == 9) check("jump u9 y", 16'(pos[0][1]), 16'd25);
            if (n == 32) check("jump u32 y", 16'(pos[0][1]), 16'd83);
            if (sprite[0] != TREX_JUMPING) landed = 1'b1;
            else if (int'(pos[0][1]) < apex) apex = int'(pos[0][1]);
        end
        check("jump land update", 16'(n), 16'd33);
        check("jump apex", 16'(apex), 16'd8);
        check_trex("jump landed", TREX_RUNNING_1, 93);

        // 4: running animation and freeze without update
        repeat (4) step(1'b0, 1'b0);
        check_trex("run 4", TREX_RUNNING_1, 93);
        step(1'b0, 1'b0);
        check_trex("run 5", TREX_RUNNING_2, 93);
        repeat (5) step(1'b0, 1'b0);
        check_trex("run 10", TREX_RUNNING_1, 93);
        jumping = 1'b1; ducking = 1'b1;
        repeat (100) @(negedge clk);
        check_trex("run frozen", TREX_RUNNING_1, 93);
        jumping = 1'b0; ducking = 1'b0;

        // 3: short jump, key released before minimum height
        step(1'b1, 1'b0);
        check_trex("short entry", TREX_JUMPING, 93);
        step(1'b1, 1'b0);
        check_trex("short u1", TREX_JUMPING, 83);
        n = 1; apex = 93; landed = 1'b0;
        while (!landed && n < 60) begin
            step(1'b0, 1'b0);
            n++;
            if (n == 4) check("short u4 y", 16'(pos[0][1]), 16'd56);
            if (n == 5) check("short u5 y", 16'(pos[0][1]), 16'd51);
            if (sprite[0] != TREX_JUMPING) landed = 1'b1;
            else if (int'(pos[0][1]) < apex) apex = int'(pos[0][1]);
        end
        check("short land update", 16'(n), 16'd27);
        check("short apex", 16'(apex), 16'd34);
        check_trex("short landed", TREX_RUNNING_1, 93);

        // 5: ducking transitions
        step(1'b0, 1'b1);
        check_trex("duck enter", TREX_DUCKING_1, 110);
        repeat (4) step(1'b0, 1'b1);
        check_trex("duck 4", TREX_DUCKING_1, 110);
        step(1'b0, 1'b1);
        check_trex("duck 5", TREX_DUCKING_2, 110);
        step(1'b0, 1'b0);
        check_trex("duck release", TREX_RUNNING_1, 93);
        step(1'b0, 1'b1);
        check_trex("duck again", TREX_DUCKING_1, 110);
        step(1'b1, 1'b1);
        check_trex("duck jump", TREX_JUMPING, 93);

        // 6: speed drop, land while ducking, reset mid-jump
        step(1'b1, 1'b0);
        check_trex("drop u1", TREX_JUMPING, 83);
        step(1'b0, 1'b1);
        check_trex("drop u2", TREX_JUMPING, 73);
        step(1'b0, 1'b1);
        check_trex("drop u3", TREX_JUMPING, 74);
        step(1'b0, 1'b1);
        check_trex("drop u4", TREX_JUMPING, 77);
        step(1'b0, 1'b1);
        check_trex("drop u5", TREX_JUMPING, 82);
        step(1'b0, 1'b1);
        check_trex("drop u6", TREX_JUMPING, 88);
        step(1'b0, 1'b1);
        check_trex("drop land", TREX_DUCKING_1, 110);
        step(1'b1, 1'b0);
        check_trex("rj entry", TREX_JUMPING, 93);
        step(1'b1, 1'b0);
        check_trex("rj u1", TREX_JUMPING, 83);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_trex("rst midjump", TREX_STANDING, 93);
        step(1'b0, 1'b0);
        check_trex("rst then idle", TREX_STANDING, 93);
        check("rst slot1 sprite", 16'(sprite[1]), 16'(NONE));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
